// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, one-entry hold buffer, redirect drop of in-flight fetches, direct-mapped BTB.
// Outputs are combinational from state and imem_ack; stall parks one fetched instruction in the hold buffer.
package if_stage_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] predicted_pc;
        logic        prediction_valid;
    } if_id_reg_t;
endpackage

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        branch_redirect_id,
    input  logic [31:0] branch_target_id,
    input  logic        bp_update_en,
    input  logic [31:0] bp_update_pc,
    input  logic [31:0] bp_update_target,
    input  logic        bp_update_taken,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output if_id_reg_t  if_id_next
);
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    if_id_reg_t  hold_q, hold_d;

    logic [BTB_ENTRIES-1:0] btb_vld_q, btb_vld_d;
    logic [TW-1:0]          btb_tag_q [BTB_ENTRIES];
    logic [TW-1:0]          btb_tag_d [BTB_ENTRIES];
    logic [31:0]            btb_tgt_q [BTB_ENTRIES];
    logic [31:0]            btb_tgt_d [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q [BTB_ENTRIES];
    logic [1:0]             btb_ctr_d [BTB_ENTRIES];

    logic [IW-1:0] lk_idx, up_idx;
    logic [TW-1:0] lk_tag, up_tag;
    logic          pred_taken, up_hit, redirect;
    logic [31:0]   next_pc, redir_tgt;
    if_id_reg_t    fetched;
    logic          unused_bits;

    assign unused_bits = ^bp_update_pc[1:0];

    // Lookup reads the registered array, so a same-cycle update is never visible.
    always_comb begin
        lk_idx     = pc_q[IW+1:2];
        lk_tag     = pc_q[31:IW+2];
        pred_taken = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) && btb_ctr_q[lk_idx][1];
        next_pc    = pred_taken ? btb_tgt_q[lk_idx] : pc_q + 32'd4;
        fetched                  = '0;
        fetched.pc               = pc_q;
        fetched.inst             = imem_rdata;
        fetched.valid            = 1'b1;
        fetched.predicted_pc     = pred_taken ? btb_tgt_q[lk_idx] : 32'd0;
        fetched.prediction_valid = pred_taken;
        redirect  = ex_redirect || branch_redirect_id;
        redir_tgt = ex_redirect ? ex_target : branch_target_id;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        hold_d      = hold_q;
        imem_req    = 1'b0;
        imem_addr   = {pc_q[31:2], 2'b00};
        if_id_next  = '0;
        case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_d = redir_tgt;
                    if (!imem_ack) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end else if (imem_ack) begin
                    pc_d = next_pc;
                    if (stall) begin
                        hold_d  = fetched;
                        state_d = S_HOLD;
                    end else begin
                        if_id_next = fetched;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redir_tgt;
                    hold_d  = '0;
                    state_d = S_REQ;
                end else if (!stall) begin
                    if_id_next = hold_q;
                    hold_d     = '0;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                // The abandoned request must keep its address until memory answers it.
                imem_req  = 1'b1;
                imem_addr = {drop_addr_q[31:2], 2'b00};
                if (redirect) pc_d = redir_tgt;
                if (imem_ack) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        if (rst) begin
            imem_req   = 1'b0;
            if_id_next = '0;
        end
    end

    always_comb begin
        up_idx    = bp_update_pc[IW+1:2];
        up_tag    = bp_update_pc[31:IW+2];
        up_hit    = btb_vld_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
        btb_vld_d = btb_vld_q;
        btb_tag_d = btb_tag_q;
        btb_tgt_d = btb_tgt_q;
        btb_ctr_d = btb_ctr_q;
        if (bp_update_en) begin
            if (up_hit) begin
                if (bp_update_taken) begin
                    if (btb_ctr_q[up_idx] != 2'b11) btb_ctr_d[up_idx] = btb_ctr_q[up_idx] + 2'd1;
                    btb_tgt_d[up_idx] = bp_update_target;
                end else if (btb_ctr_q[up_idx] != 2'b00) begin
                    btb_ctr_d[up_idx] = btb_ctr_q[up_idx] - 2'd1;
                end
            end else if (bp_update_taken) begin
                btb_vld_d[up_idx] = 1'b1;
                btb_tag_d[up_idx] = up_tag;
                btb_tgt_d[up_idx] = bp_update_target;
                btb_ctr_d[up_idx] = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            hold_q      <= '0;
            btb_vld_q   <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                btb_ctr_q[i] <= 2'b01;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            hold_q      <= hold_d;
            btb_vld_q   <= btb_vld_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
            btb_ctr_q   <= btb_ctr_d;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes expected issues into a queue, a negedge monitor pops and compares.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, ex_redirect, branch_redirect_id, bp_update_en, bp_update_taken, imem_ack;
    logic [31:0] ex_target, branch_target_id, bp_update_pc, bp_update_target;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    if_id_reg_t  if_id_next;

    int         n_vec = 0;
    int         n_err = 0;
    if_id_reg_t exp_q[$];
    if_id_reg_t mon_e;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .branch_redirect_id(branch_redirect_id), .branch_target_id(branch_target_id),
        .bp_update_en(bp_update_en), .bp_update_pc(bp_update_pc),
        .bp_update_target(bp_update_target), .bp_update_taken(bp_update_taken),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_id_next(if_id_next)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = inst_of(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        imem_ack = 0; stall = 0; ex_redirect = 0; branch_redirect_id = 0;
        bp_update_en = 0; bp_update_taken = 0;
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic pv, input logic [31:0] ppc);
        if_id_reg_t e;
        chk("fetch_addr", imem_addr, a);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1;
        e = '0;
        e.pc = a; e.inst = inst_of(a); e.valid = 1'b1;
        e.predicted_pc = ppc; e.prediction_valid = pv;
        exp_q.push_back(e);
    endtask

    task automatic bp_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bp_update_en = 1; bp_update_pc = pc; bp_update_taken = tk; bp_update_target = tgt;
    endtask

    always @(negedge clk) begin
        n_vec++;
        if (if_id_next.valid) begin
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_issue: got pc %h, expected no issue", if_id_next.pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (if_id_next !== mon_e) begin
                    n_err++;
                    $display("FAIL issue_pc%h: got {pc %h inst %h pv %b ppc %h}, expected {pc %h inst %h pv %b ppc %h}",
                             mon_e.pc, if_id_next.pc, if_id_next.inst, if_id_next.prediction_valid,
                             if_id_next.predicted_pc, mon_e.pc, mon_e.inst, mon_e.prediction_valid,
                             mon_e.predicted_pc);
                end
            end
        end else if (if_id_next !== '0) begin
            n_err++;
            $display("FAIL idle_fields_zero: got %h, expected 0", if_id_next);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; stall = 0; ex_redirect = 0; branch_redirect_id = 0; bp_update_en = 0;
        bp_update_taken = 0; imem_ack = 0; ex_target = 0; branch_target_id = 0;
        bp_update_pc = 0; bp_update_target = 0;
        repeat (2) @(posedge clk);
        #1; imem_ack = 1; #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_out_zero", {31'd0, (if_id_next != '0)}, 32'd0);

        // Reset release and straight-line fetch
        nxt(); rst = 0; #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            fetch(32'(i * 4), 1'b0, 32'd0);
        end

        // Stall on the ack at 0x10 for three cycles
        nxt(); chk("pre_stall_addr", imem_addr, 32'h10);
        imem_ack = 1; stall = 1; #1;
        chk("stall_valid0", {31'd0, if_id_next.valid}, 32'd0);
        nxt(); stall = 1; #1; chk("hold_req0", {31'd0, imem_req}, 32'd0);
        nxt(); stall = 1; #1; chk("hold_req0b", {31'd0, imem_req}, 32'd0);
        nxt();
        begin
            if_id_reg_t e;
            e = '0; e.pc = 32'h10; e.inst = inst_of(32'h10); e.valid = 1'b1;
            exp_q.push_back(e);
        end
        nxt(); chk("after_hold_addr", imem_addr, 32'h14);
        fetch(32'h14, 1'b0, 32'd0);
        nxt(); fetch(32'h18, 1'b0, 32'd0);
        nxt(); fetch(32'h1C, 1'b0, 32'd0);

        // EX redirect while 0x20 is in flight
        nxt(); chk("pend_addr", imem_addr, 32'h20);
        nxt(); ex_redirect = 1; ex_target = 32'h100;
        nxt(); chk("drop_addr", imem_addr, 32'h20); chk("drop_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1; #1; chk("drop_discard", {31'd0, if_id_next.valid}, 32'd0);
        nxt(); fetch(32'h100, 1'b0, 32'd0);

        // Simultaneous EX and ID redirects, then ID redirect alone with ack
        nxt(); ex_redirect = 1; ex_target = 32'h200; branch_redirect_id = 1; branch_target_id = 32'h300;
        nxt(); chk("drop_addr2", imem_addr, 32'h104); imem_ack = 1;
        nxt(); fetch(32'h200, 1'b0, 32'd0);
        nxt(); imem_ack = 1; branch_redirect_id = 1; branch_target_id = 32'h300; #1;
        chk("id_redir_valid0", {31'd0, if_id_next.valid}, 32'd0);
        nxt(); chk("id_redir_addr", imem_addr, 32'h300);

        // BTB training and prediction
        bp_upd(32'h40, 1'b1, 32'h80); ex_redirect = 1; ex_target = 32'h40;
        nxt(); imem_ack = 1;
        nxt(); fetch(32'h40, 1'b1, 32'h80);
        nxt(); fetch(32'h80, 1'b0, 32'd0);
        nxt(); ex_redirect = 1; ex_target = 32'h40;
        nxt(); imem_ack = 1;
        nxt(); fetch(32'h40, 1'b1, 32'h80); bp_upd(32'h40, 1'b0, 32'h0);
        nxt(); chk("pred_next_addr", imem_addr, 32'h80);
        bp_upd(32'h40, 1'b0, 32'h0); ex_redirect = 1; ex_target = 32'h40;
        nxt(); imem_ack = 1;
        nxt(); fetch(32'h40, 1'b0, 32'd0);
        nxt(); chk("untrained_next", imem_addr, 32'h44);

        // Reset in the middle of HOLD
        imem_ack = 1; stall = 1;
        nxt(); stall = 1; #1; chk("hold2_req0", {31'd0, imem_req}, 32'd0);
        nxt(); rst = 1; #1;
        chk("rst_hold_out", {31'd0, (if_id_next != '0)}, 32'd0);
        chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
        nxt(); rst = 0; #1;
        chk("restart_addr", imem_addr, 32'h0);
        fetch(32'h0, 1'b0, 32'd0);
        repeat (3) nxt();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BTB_ENTRIES, default 16: direct-mapped BTB depth, power of two; index width IW = log2(BTB_ENTRIES).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  downstream cannot accept a new instruction this cycle.
REQ-006 ex_redirect  input  1  EX-stage mispredict/jump redirect.
REQ-007 ex_target  input  32  EX redirect address.
REQ-008 branch_redirect_id  input  1  ID early-branch redirect.
REQ-009 branch_target_id  input  32  ID redirect address.
REQ-010 bp_update_en  input  1  resolved-branch BTB update strobe from EX.
REQ-011 bp_update_pc / bp_update_target  input  32 each  resolved branch PC / taken target.
REQ-012 bp_update_taken  input  1  resolved direction.
REQ-013 imem_req  output  1  instruction fetch request.
REQ-014 imem_addr  output  32  fetch address, word aligned.
REQ-015 imem_ack  input  1  fetch completes this cycle; imem_rdata valid.
REQ-016 imem_rdata  input  32  fetched instruction.
REQ-017 if_id_next  output  if_id_reg_t  {pc, inst, valid, predicted_pc, prediction_valid}, registered into the IF/ID pipeline register outside this block.

Function
REQ-018 State: pc_reg (32), FSM {REQ, HOLD, DROP}, hold buffer {pc, inst, predicted_pc, prediction_valid}, BTB array.
REQ-019 REQ: imem_req=1, imem_addr=pc_reg; pc_reg and imem_addr SHALL stay stable until imem_ack.
REQ-020 Lookup on pc_reg: idx=pc_reg[IW+1:2], tag=pc_reg[31:IW+2]; hit = entry valid and tag match; predict taken = hit and counter[1]=1.
REQ-021 next_pc = BTB target if predict taken, else pc_reg+4 (32-bit wrap, carry discarded).
REQ-022 REQ, imem_ack=1, no redirect, stall=0: if_id_next.valid=1, pc=pc_reg, inst=imem_rdata, prediction_valid=predict taken, predicted_pc=BTB target (0 if not predicted); pc_reg<=next_pc; stay REQ.
REQ-023 REQ, imem_ack=1, no redirect, stall=1: capture same fields into hold buffer, pc_reg<=next_pc, go HOLD; if_id_next.valid=0.
REQ-024 HOLD: imem_req=0; stall=1 stay; stall=0 present hold buffer with valid=1, go REQ.
REQ-025 Redirect priority: ex_redirect over branch_redirect_id; target = ex_target or branch_target_id respectively.
REQ-026 Any redirect: pc_reg<=target; if_id_next.valid=0 that cycle; hold buffer discarded; ack data that cycle discarded.
REQ-027 Redirect in REQ without imem_ack: go DROP (request in flight). Redirect with imem_ack, or in HOLD/DROP-with-ack: go REQ.
REQ-028 DROP: imem_req=1, imem_addr=old address held until ack; on ack discard data, go REQ. Further redirect in DROP updates pc_reg only.
REQ-029 No instruction SHALL be issued twice or skipped absent a redirect.
REQ-030 All if_id_next fields SHALL be 0 whenever valid=0.
REQ-031 BTB update on bp_update_en at index/tag of bp_update_pc: miss+taken -> allocate valid=1, tag, target, counter=2'b10; miss+not taken -> no change; hit -> counter saturating +1 (taken) / -1 (not taken), target overwritten when taken.
REQ-032 Same-cycle update and lookup on one index: lookup SHALL use the pre-update entry.

Reset
REQ-033 While rst=1: pc_reg=RESET_PC, FSM=REQ, imem_req=0, if_id_next=0, hold buffer empty, all BTB valid bits 0, counters 2'b01.
REQ-034 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC; rst mid-request abandons it with no output.

Verification
REQ-035 Reset release, imem_ack every cycle, empty BTB -> consecutive valid instructions at pc 0,4,8,12, prediction_valid=0.
REQ-036 Ack at pc 0x10 while stall=1 for 3 cycles -> valid=0 for 3 cycles, then pc=0x10 issued once with captured inst, next request 0x14.
REQ-037 Request 0x20 pending (no ack), ex_redirect=1 target 0x100 -> DROP; late ack for 0x20 discarded; next issued pc=0x100.
REQ-038 ex_redirect to 0x200 and branch_redirect_id to 0x300 same cycle -> next fetch 0x200.
REQ-039 bp_update_en pc=0x40 taken target=0x80, then fetch 0x40 -> prediction_valid=1, predicted_pc=0x80, next fetch 0x80; two not-taken updates -> 0x40 then fetches 0x44.
REQ-040 rst asserted mid-HOLD -> all outputs 0 immediately, hold content never issued, fetch restarts at RESET_PC.
